// File: rtl/uart_rx_sipo.sv
// Serial-in/parallel-out UART receiver: 2-flop line synchronizer, mid-bit sampling FSM,
// MSB-first reassembly with single-cycle valid / framing-error strobes.
module uart_rx_sipo #(
    parameter int unsigned DW           = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enb,
    input  logic          rx_in,
    output logic [DW-1:0] data_out,
    output logic          data_valid,
    output logic          frame_err,
    output logic          busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DW);

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DW - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] shreg_q;
    logic          rx_meta_q;
    logic          rx_s;

    // Line synchronizer; both flops reset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s      <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!enb) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                idx_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= StStart;
                        end
                    end
                    StStart: begin
                        if (cnt_q == CNT_HALF) begin
                            cnt_q <= '0;
                            idx_q <= '0;
                            // A start bit that is gone by mid-bit is treated as noise.
                            state_q <= rx_s ? StIdle : StData;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StData: begin
                        if (cnt_q == CNT_FULL) begin
                            cnt_q   <= '0;
                            shreg_q <= {shreg_q[DW-2:0], rx_s};
                            idx_q   <= idx_q + IW'(1);
                            if (idx_q == IDX_LAST) begin
                                state_q <= StStop;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StStop: begin
                        // Leaving mid-stop-bit lets a following start edge be caught gap-free.
                        if (cnt_q == CNT_FULL) begin
                            cnt_q <= '0;
                            if (rx_s) begin
                                data_out   <= shreg_q;
                                data_valid <= 1'b1;
                                state_q    <= StIdle;
                            end else begin
                                frame_err <= 1'b1;
                                state_q   <= StBreak;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StBreak: begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: framing, glitch rejection, framing error, back-to-back,
// reset / enable abort and a PISO loopback frame.
module tb_uart_rx_sipo;

    logic       clk;
    logic       reset;
    logic       enb;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int total;
    int bad;

    int cyc;
    int valid_cnt;
    int err_cnt;
    int busy_cnt;
    int both_cnt;
    int long_cnt;
    int valid_cyc;
    logic prev_strobe;
    logic [7:0] rx_log [0:7];

    uart_rx_sipo #(
        .DW          (8),
        .CLKS_PER_BIT(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enb       (enb),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            if (valid_cnt < 8) rx_log[valid_cnt] = data_out;
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (frame_err) err_cnt = err_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (data_valid && frame_err) both_cnt = both_cnt + 1;
        if ((data_valid || frame_err) && prev_strobe) long_cnt = long_cnt + 1;
        prev_strobe = data_valid || frame_err;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        valid_cnt = 0;
        err_cnt   = 0;
        busy_cnt  = 0;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        rx_in = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 8; i++) begin
            rx_in = data[7-i];
            wait_cycles(16);
        end
        rx_in = stop_bit;
        wait_cycles(16);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enb   = 1'b1;
        rx_in = 1'b1;
        wait_cycles(3);
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", data_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        reset = 1'b1;
        wait_cycles(5);
    endtask

    task automatic test_frame();
        int start_cyc;
        clear_counts();
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        rx_in = 1'b1;
        wait_cycles(20);
        total++; if (valid_cnt !== 1) begin bad++; $display("FAIL a5_valid_count got=%0d want=1", valid_cnt); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", data_out); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL a5_err_count got=%0d want=0", err_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL a5_busy got=%b want=0", busy); end
        // 2 sync + 1 detect + 8 half-bit + 9*16 bits = 155 cycles after the start edge
        total++;
        if ((valid_cyc - start_cyc) < 154 || (valid_cyc - start_cyc) > 156) begin
            bad++; $display("FAIL a5_latency got=%0d want=155", valid_cyc - start_cyc);
        end
    endtask

    task automatic test_glitch();
        clear_counts();
        rx_in = 1'b0;
        wait_cycles(4);
        rx_in = 1'b1;
        wait_cycles(30);
        total++; if (busy_cnt < 7 || busy_cnt > 9) begin bad++; $display("FAIL glitch_busy_len got=%0d want=8", busy_cnt); end
        total++; if (valid_cnt !== 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", valid_cnt); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL glitch_err got=%0d want=0", err_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", busy); end
    endtask

    task automatic test_frame_err();
        clear_counts();
        send_frame(8'h3C, 1'b0);
        wait_cycles(40);
        total++; if (err_cnt !== 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", err_cnt); end
        total++; if (valid_cnt !== 0) begin bad++; $display("FAIL ferr_valid got=%0d want=0", valid_cnt); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL ferr_data_held got=%h want=a5", data_out); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_break got=%b want=1", busy); end
        rx_in = 1'b1;
        wait_cycles(200);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release got=%b want=0", busy); end
        total++; if (valid_cnt !== 0 || err_cnt !== 1) begin
            bad++; $display("FAIL ferr_spurious got valid=%0d err=%0d want valid=0 err=1", valid_cnt, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        rx_in = 1'b1;
        wait_cycles(20);
        total++; if (valid_cnt !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", valid_cnt); end
        total++; if (rx_log[0] !== 8'h3C) begin bad++; $display("FAIL b2b_first got=%h want=3c", rx_log[0]); end
        total++; if (rx_log[1] !== 8'hC3) begin bad++; $display("FAIL b2b_second got=%h want=c3", rx_log[1]); end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL b2b_err got=%0d want=0", err_cnt); end
    endtask

    task automatic partial_ff();
        rx_in = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 4; i++) begin
            rx_in = 1'b1;
            wait_cycles(16);
        end
        wait_cycles(8);
    endtask

    task automatic test_abort_reset();
        clear_counts();
        partial_ff();
        reset = 1'b0;
        #1;
        total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_abort_data got=%h want=00", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_abort_busy got=%b want=0", busy); end
        total++; if (data_valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL rst_abort_strobes got=%b%b want=00", data_valid, frame_err);
        end
        wait_cycles(4);
        reset = 1'b1;
        wait_cycles(150);
        total++; if (valid_cnt !== 0) begin bad++; $display("FAIL rst_abort_partial got=%0d want=0", valid_cnt); end
        send_frame(8'h81, 1'b1);
        wait_cycles(20);
        total++; if (valid_cnt !== 1) begin bad++; $display("FAIL rst_next_count got=%0d want=1", valid_cnt); end
        total++; if (data_out !== 8'h81) begin bad++; $display("FAIL rst_next_data got=%h want=81", data_out); end
    endtask

    task automatic test_abort_enb();
        clear_counts();
        partial_ff();
        enb = 1'b0;
        wait_cycles(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL enb_abort_busy got=%b want=0", busy); end
        // Line stays high, so an ignored enb would finish the frame as 0xFF.
        wait_cycles(150);
        total++; if (valid_cnt !== 0 || err_cnt !== 0) begin
            bad++; $display("FAIL enb_abort_strobes got valid=%0d err=%0d want 0 0", valid_cnt, err_cnt);
        end
        total++; if (data_out !== 8'h81) begin bad++; $display("FAIL enb_abort_data got=%h want=81", data_out); end
        enb = 1'b1;
        wait_cycles(5);
        send_frame(8'h81, 1'b1);
        wait_cycles(20);
        total++; if (valid_cnt !== 1) begin bad++; $display("FAIL enb_next_count got=%0d want=1", valid_cnt); end
        total++; if (data_out !== 8'h81) begin bad++; $display("FAIL enb_next_data got=%h want=81", data_out); end
    endtask

    task automatic test_loopback();
        logic [9:0] piso;
        clear_counts();
        piso = {1'b0, 8'h96, 1'b1};
        for (int i = 0; i < 10; i++) begin
            rx_in = piso[9];
            piso  = {piso[8:0], 1'b1};
            wait_cycles(16);
        end
        wait_cycles(20);
        total++; if (valid_cnt !== 1) begin bad++; $display("FAIL loop_count got=%0d want=1", valid_cnt); end
        total++; if (data_out !== 8'h96) begin bad++; $display("FAIL loop_data got=%h want=96", data_out); end
    endtask

    task automatic test_strobes();
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", both_cnt); end
        total++; if (long_cnt !== 0) begin bad++; $display("FAIL strobe_width got=%0d want=0", long_cnt); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        valid_cnt   = 0;
        err_cnt     = 0;
        busy_cnt    = 0;
        both_cnt    = 0;
        long_cnt    = 0;
        valid_cyc   = 0;
        prev_strobe = 1'b0;
        for (int i = 0; i < 8; i++) rx_log[i] = 8'h00;
        test_reset();
        test_frame();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_abort_reset();
        test_abort_enb();
        test_loopback();
        test_strobes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
